// File: rtl/led_ctrl.sv
// LED front-end control: per-button synchroniser, debouncer and press detector,
// a mode FSM producing the one-hot command vector, and the shift-strobe divider.
//
// state   | meaning
// --------+----------------------------------------------
// IDLE    | no shift mode latched; state[0] = state[2] = 0
// SHIFT_L | left-shift mode; state[0] = 1
// SHIFT_R | right-shift mode; state[2] = 1
module led_ctrl #(
   parameter int CLK_HZ          = 100_000_000,
   parameter int STROBE_HZ       = 1,
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btnl,
   input  logic       btnu,
   input  logic       btnr,
   input  logic       btnd,
   output logic [3:0] state,
   output logic       strobe_1hz
);

   localparam int P  = CLK_HZ / STROBE_HZ;
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int PW = $clog2(P);

   localparam logic [DW-1:0] DB_MAX  = DW'(DEBOUNCE_CYCLES);
   localparam logic [DW-1:0] DB_ONE  = DW'(1);
   localparam logic [PW-1:0] DIV_MAX = PW'(P - 1);
   localparam logic [PW-1:0] DIV_ONE = PW'(1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SHIFT_L = 2'd1,
      SHIFT_R = 2'd2
   } mode_t;

   // Button bit order matches the command vector: left, load, right, clear.
   logic [3:0]    raw;
   logic [3:0]    sync1;
   logic [3:0]    s;
   logic [3:0]    db;
   logic [3:0]    db_q;
   logic [3:0]    press;
   logic [DW-1:0] db_cnt [4];

   mode_t         mode;
   mode_t         mode_nxt;
   logic [3:0]    state_nxt;
   logic          ld_nxt;
   logic          clr_nxt;
   logic          div_clr;
   logic [PW-1:0] div_cnt;

   assign raw = {btnd, btnr, btnu, btnl};

   // A level change is accepted only after the counter has reached the limit
   // and the synchronised input still disagrees with the debounced level.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= '0;
         s     <= '0;
         db    <= '0;
         db_q  <= '0;
         for (int i = 0; i < 4; i++) begin
            db_cnt[i] <= '0;
         end
      end else begin
         sync1 <= raw;
         s     <= sync1;
         db_q  <= db;
         for (int i = 0; i < 4; i++) begin
            if (s[i] == db[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_MAX) begin
               db[i]     <= ~db[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + DB_ONE;
            end
         end
      end
   end

   assign press = db & ~db_q;

   // Priority: clear > load > left > right; load leaves the mode and divider alone.
   always_comb begin
      mode_nxt = mode;
      ld_nxt   = 1'b0;
      clr_nxt  = 1'b0;
      div_clr  = 1'b0;
      if (press[3]) begin
         mode_nxt = IDLE;
         clr_nxt  = 1'b1;
         div_clr  = 1'b1;
      end else if (press[1]) begin
         ld_nxt = 1'b1;
      end else if (press[0]) begin
         mode_nxt = SHIFT_L;
         div_clr  = 1'b1;
      end else if (press[2]) begin
         mode_nxt = SHIFT_R;
         div_clr  = 1'b1;
      end
      state_nxt = {clr_nxt, mode_nxt == SHIFT_R, ld_nxt, mode_nxt == SHIFT_L};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode  <= IDLE;
         state <= 4'b0000;
      end else begin
         mode  <= mode_nxt;
         state <= state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || div_clr) begin
         div_cnt <= '0;
      end else if (div_cnt == DIV_MAX) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DIV_ONE;
      end
   end

   assign strobe_1hz = (div_cnt == DIV_MAX);

endmodule

// File: doc/led_ctrl.md
Name: led_ctrl

Overview:
Front-end control stage feeding the LED shift register. Takes the four raw push-buttons (btnl, btnu, btnr, btnd) and produces two outputs: the one-hot 4-bit `state` command vector and the 1 Hz shift strobe `strobe_1hz` that the shift register consumes. Each button goes through a synchroniser, debouncer and rising-edge detector. A mode FSM latches the shift direction, and a strobe divider paces the shifts.

Parameters:
CLK_HZ, 100_000_000, input clock frequency in Hz
STROBE_HZ, 1, strobe rate; divider period P = CLK_HZ/STROBE_HZ cycles (integer, P >= 2)
DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles needed to accept a button level change (>= 1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
btnl  input  1  raw asynchronous button: select left-shift mode
btnu  input  1  raw asynchronous button: load
btnr  input  1  raw asynchronous button: select right-shift mode
btnd  input  1  raw asynchronous button: clear
state  output  4  command vector: bit0 left-shift, bit1 load, bit2 right-shift, bit3 clear
strobe_1hz  output  1  one-cycle shift strobe, period P

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high. Every flop, including the synchronisers, clears on rst.
- Reset values:
  - state = 4'b0000, strobe_1hz = 0.
  - FSM = IDLE.
  - Debounced levels = 0, all counters = 0.
- Per button, synchroniser: 2-flop synchroniser producing s.
- Per button, debouncer:
  - Debounce counter increments each cycle while s != db, and clears whenever s == db.
  - When the counter reaches DEBOUNCE_CYCLES, db toggles and the counter clears.
- Per button, press event: pulse = db & ~db_q (db delayed by one cycle).
  - Release generates no event.
  - A held button generates exactly one event.
- Press latency: a clean press first sampled at edge 0 changes `state` at edge DEBOUNCE_CYCLES+3.
- Glitches of fewer than DEBOUNCE_CYCLES stable cycles produce no event.
- FSM states: IDLE, SHIFT_L, SHIFT_R. Outputs are registered.
  - IDLE: state[0] = state[2] = 0.
  - SHIFT_L: state[0] = 1.
  - SHIFT_R: state[2] = 1.
- Events are resolved in the same cycle with priority clear > load > left > right.
  - clear: FSM goes to IDLE; state[3] = 1 for exactly one cycle; shift bits go 0 in that same cycle.
  - load: state[1] = 1 for exactly one cycle; FSM mode unchanged (shift bit stays asserted). Lower-priority events in the same cycle are dropped.
  - left: FSM goes to SHIFT_L (from any state, including SHIFT_L).
  - right: FSM goes to SHIFT_R.
  - Left and right pressed in the same cycle: left wins; right is dropped.
- Output encoding:
  - state[1] and state[3] are never asserted together, and never for more than one cycle per event.
  - state[0] and state[2] are mutually exclusive.
- Strobe divider:
  - Counter runs 0..P-1 and wraps to 0.
  - strobe_1hz = 1 for exactly the one cycle in which the counter equals P-1.
  - The counter runs free in all FSM states, including IDLE.
  - Any accepted left, right or clear event clears the counter to 0 in the same cycle the FSM updates. The first strobe therefore follows P cycles after the mode bit asserts.
  - A load event does not touch the counter.
- Reset mid-operation: rst asserted in any cycle forces all reset values at the next edge. Any in-progress debounce count is discarded, and a button still held after reset is re-debounced from 0 and then yields one event.

Test Plan:
Bench parameters for all scenarios: CLK_HZ=20, STROBE_HZ=1 (P=20), DEBOUNCE_CYCLES=4.

1. Reset: hold rst for 3 cycles with btnl=1 -> state=0000 and strobe_1hz=0 throughout. After rst deasserts, state=0001 exactly 7 edges later.
2. Left then strobe: press btnl cleanly; state=0001 at edge 7 -> strobe_1hz high only in the cycle where the counter is 19 (20 cycles after the mode bit), then every 20 cycles. Holding btnl for 100 cycles gives no further event.
3. Bounce: btnr toggled 1,0,1,0 with 2-cycle dwell, then held low -> state unchanged, no event. Then btnr held high -> state=0100 at edge 7, and state[0]=0.
4. Load while shifting: in SHIFT_R, press btnu -> one cycle of state=0110, then state=0100; strobe phase unchanged.
5. Simultaneous events: btnd and btnl debounced in the same cycle -> state=1000 for one cycle, then 0000; FSM IDLE; counter cleared. btnl and btnr together -> state=0001.
6. Mode switch resets divider: in SHIFT_L at counter=12, press btnr -> state=0100; next strobe exactly 20 cycles after the switch, not 8.
